// File: rtl/memblock_bank.sv
// Double-buffered per-channel operand store with a clear sequencer and registered reads.
// Optional per-word even parity is built when MEMBLOCK_PARITY_EN is defined.
module memblock_bank #(
    parameter int N        = 8,
    parameter int CHANNELS = 3,
    parameter int ADDR_W   = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [ADDR_W-1:0]          Wr_Addr,
    input  logic [CHANNELS*(N+1)-1:0]  Data_In,
    input  logic [CHANNELS-1:0]        Wr_En,
    input  logic [ADDR_W-1:0]          Rd_Addr,
    input  logic                       Rd_En,
    input  logic                       Swap,
    input  logic                       Clear,
    output logic [CHANNELS*(N+1)-1:0]  Data_Out,
    output logic                       Rd_Valid,
    output logic                       Bank,
    output logic                       Busy,
    output logic [CHANNELS-1:0]        Parity_Err
);
    localparam int W     = N + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic                      bank_q, bank_d;
    logic [CHANNELS*W-1:0]     data_out_q, data_out_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rd_fire;
    logic                      clr_fire;
    logic [CHANNELS-1:0]       wr_fire;

    logic [W-1:0] mem_q [2][CHANNELS][DEPTH];

    always_comb begin
        rd_fire  = (state_q == IDLE) && Rd_En;
        wr_fire  = (state_q == IDLE) ? Wr_En : '0;
        clr_fire = (state_q == CLEAR);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (Swap) begin
                    bank_d = ~bank_q;
                end
                if (Clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads always see the pre-edge bank, so a same-cycle Swap does not disturb them.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_fire;
        if (rd_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                data_out_d[c*W +: W] = mem_q[bank_q][c][Rd_Addr];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bank_q     <= 1'b0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset; the clear sequence wipes both banks at the counter address.
    always_ff @(posedge Clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (clr_fire) begin
                mem_q[0][c][cnt_q] <= '0;
                mem_q[1][c][cnt_q] <= '0;
            end else if (wr_fire[c]) begin
                mem_q[~bank_q][c][Wr_Addr] <= Data_In[c*W +: W];
            end
        end
    end

`ifdef MEMBLOCK_PARITY_EN
    logic                par_q [2][CHANNELS][DEPTH];
    logic [CHANNELS-1:0] par_err_q, par_err_d;

    always_comb begin
        par_err_d = '0;
        if (rd_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                par_err_d[c] = (^mem_q[bank_q][c][Rd_Addr]) != par_q[bank_q][c][Rd_Addr];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            par_err_q <= '0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    always_ff @(posedge Clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (clr_fire) begin
                par_q[0][c][cnt_q] <= 1'b0;
                par_q[1][c][cnt_q] <= 1'b0;
            end else if (wr_fire[c]) begin
                par_q[~bank_q][c][Wr_Addr] <= ^Data_In[c*W +: W];
            end
        end
    end

    assign Parity_Err = par_err_q;
`else
    assign Parity_Err = '0;
`endif

    assign Data_Out = data_out_q;
    assign Rd_Valid = rd_valid_q;
    assign Bank     = bank_q;
    assign Busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_memblock_bank.sv
// Directed bench for memblock_bank: clear timing, bank swapping, busy lockout,
// reset abort of a clear, and (with MEMBLOCK_PARITY_EN) parity error reporting.
module tb_memblock_bank;
    localparam int N  = 8;
    localparam int CH = 3;
    localparam int AW = 4;
    localparam int W  = N + 1;

    logic              Clock;
    logic              Reset;
    logic [AW-1:0]     Wr_Addr;
    logic [CH*W-1:0]   Data_In;
    logic [CH-1:0]     Wr_En;
    logic [AW-1:0]     Rd_Addr;
    logic              Rd_En;
    logic              Swap;
    logic              Clear;
    logic [CH*W-1:0]   Data_Out;
    logic              Rd_Valid;
    logic              Bank;
    logic              Busy;
    logic [CH-1:0]     Parity_Err;

    int n_assert;
    int n_fail;
    int busy_cnt;

    memblock_bank #(.N(N), .CHANNELS(CH), .ADDR_W(AW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Wr_Addr    (Wr_Addr),
        .Data_In    (Data_In),
        .Wr_En      (Wr_En),
        .Rd_Addr    (Rd_Addr),
        .Rd_En      (Rd_En),
        .Swap       (Swap),
        .Clear      (Clear),
        .Data_Out   (Data_Out),
        .Rd_Valid   (Rd_Valid),
        .Bank       (Bank),
        .Busy       (Busy),
        .Parity_Err (Parity_Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [CH*W-1:0] pack3(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                              input logic [W-1:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        Rd_Addr = a;
        Rd_En   = 1'b1;
        tick();
        Rd_En   = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Wr_Addr  = '0;
        Data_In  = '0;
        Wr_En    = '0;
        Rd_Addr  = '0;
        Rd_En    = 1'b0;
        Swap     = 1'b0;
        Clear    = 1'b0;
        tick();
        tick();
        chk("rst_bank", Bank, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_rdvalid", Rd_Valid, 0);
        chk("rst_dout", Data_Out, 0);
        chk("rst_perr", Parity_Err, 0);
        Reset = 1'b0;
        tick();

        // Clear with all commands (including another Clear) hammered while busy
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("busy_start", Busy, 1);
        busy_cnt = 1;
        Wr_En   = 3'b111;
        Data_In = pack3(9'h1FF, 9'h1FF, 9'h1FF);
        Wr_Addr = 4'd5;
        Rd_En   = 1'b1;
        Rd_Addr = 4'd5;
        Swap    = 1'b1;
        Clear   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Busy !== 1'b1) break;
            busy_cnt++;
            chk("busy_rdvalid", Rd_Valid, 0);
            chk("busy_bank", Bank, 0);
        end
        Wr_En = '0;
        Rd_En = 1'b0;
        Swap  = 1'b0;
        Clear = 1'b0;
        chk("busy_len", busy_cnt, 16);
        chk("post_clr_rdvalid", Rd_Valid, 0);
        chk("post_clr_bank", Bank, 0);

        // Back-to-back reads of every address in both banks
        for (int a = 0; a < 16; a++) begin
            Rd_Addr = AW'(a);
            Rd_En   = 1'b1;
            tick();
            chk("clr_b0_valid", Rd_Valid, 1);
            chk("clr_b0_data", Data_Out, 0);
        end
        Rd_En = 1'b0;
        Swap  = 1'b1;
        tick();
        Swap  = 1'b0;
        chk("swap1_bank", Bank, 1);
        chk("swap1_rdvalid", Rd_Valid, 0);
        for (int a = 0; a < 16; a++) begin
            Rd_Addr = AW'(a);
            Rd_En   = 1'b1;
            tick();
            chk("clr_b1_valid", Rd_Valid, 1);
            chk("clr_b1_data", Data_Out, 0);
        end
        Rd_En = 1'b0;
        Swap  = 1'b1;
        tick();
        Swap  = 1'b0;
        chk("swap2_bank", Bank, 0);

        // Write goes to the shadow bank; visible only after a swap
        Wr_En   = 3'b001;
        Wr_Addr = 4'd3;
        Data_In = pack3(9'h1A5, 9'h000, 9'h000);
        tick();
        Wr_En   = '0;
        rd(4'd3);
        chk("noswap_valid", Rd_Valid, 1);
        chk("noswap_data", Data_Out, 0);
        Swap = 1'b1;
        tick();
        Swap = 1'b0;
        chk("swap3_bank", Bank, 1);
        rd(4'd3);
        chk("wr_a3_valid", Rd_Valid, 1);
        chk("wr_a3_data", Data_Out, pack3(9'h1A5, 9'h000, 9'h000));
        tick();
        chk("hold_valid", Rd_Valid, 0);
        chk("hold_data", Data_Out, pack3(9'h1A5, 9'h000, 9'h000));

        // Write together with Swap is readable on the very next cycle
        Wr_En   = 3'b111;
        Wr_Addr = 4'd7;
        Data_In = pack3(9'h001, 9'h002, 9'h003);
        Swap    = 1'b1;
        tick();
        Wr_En   = '0;
        Swap    = 1'b0;
        chk("swap4_bank", Bank, 0);
        rd(4'd7);
        chk("same_cyc_data", Data_Out, pack3(9'h001, 9'h002, 9'h003));

        // Channel independence: only channel 1 is written
        Wr_En   = 3'b010;
        Wr_Addr = 4'd7;
        Data_In = pack3(9'h1FF, 9'h1FF, 9'h1FF);
        Swap    = 1'b1;
        tick();
        Wr_En   = '0;
        Swap    = 1'b0;
        chk("swap5_bank", Bank, 1);
        rd(4'd7);
        chk("ch1_only_data", Data_Out, pack3(9'h000, 9'h1FF, 9'h000));

        // Seed bank 0, then abort a clear with reset after four addresses are wiped
        Wr_En   = 3'b111;
        Wr_Addr = 4'd10;
        Data_In = pack3(9'h0AA, 9'h055, 9'h123);
        tick();
        Wr_Addr = 4'd2;
        Data_In = pack3(9'h111, 9'h111, 9'h111);
        tick();
        Wr_En   = '0;
        Clear   = 1'b1;
        tick();
        Clear   = 1'b0;
        chk("clr2_busy", Busy, 1);
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_bank", Bank, 0);
        chk("abort_dout", Data_Out, 0);
        tick();
        Reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(AW'(a));
            chk("abort_lo_data", Data_Out, 0);
        end
        rd(4'd10);
        chk("abort_a10_valid", Rd_Valid, 1);
        chk("abort_a10_data", Data_Out, pack3(9'h0AA, 9'h055, 9'h123));

`ifdef MEMBLOCK_PARITY_EN
        Wr_En   = 3'b001;
        Wr_Addr = 4'd5;
        Data_In = pack3(9'h0FF, 9'h000, 9'h000);
        Swap    = 1'b1;
        tick();
        Wr_En   = '0;
        Swap    = 1'b0;
        force dut.mem_q[1][0][5][0] = 1'b0;
        rd(4'd5);
        chk("par_err_valid", Rd_Valid, 1);
        chk("par_err_bits", Parity_Err, 3'b001);
        release dut.mem_q[1][0][5][0];
        rd(4'd7);
        chk("par_ok_bits", Parity_Err, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memblock_bank.md
# memblock_bank

Parametrised, double-buffered storage bank for the radix-8 Booth datapath. It generalises the fixed three-slot operand store to CHANNELS independent channels of 2^ADDR_W words each. Every channel has a shadow bank that is written while the active bank is read, and the banks swap roles on command. A built-in clear sequencer zeroes all storage, and optional per-word parity is available. It sits between the operand loader and the Booth recoding/accumulate stages.

## Interface
- N, 8, word width is N+1 bits (sign-extension bit included, as elsewhere in the datapath)
- CHANNELS, 3, number of independent channels (operand A, B, C by default)
- ADDR_W, 4, address width; depth per bank = 2^ADDR_W words
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- Wr_Addr  in  ADDR_W  write address, shared by all channels
- Data_In  in  CHANNELS*(N+1)  write data; channel c at [c*(N+1) +: N+1]
- Wr_En  in  CHANNELS  per-channel write enable
- Rd_Addr  in  ADDR_W  read address, shared by all channels
- Rd_En  in  1  read strobe, all channels
- Swap  in  1  exchange active and shadow banks
- Clear  in  1  start the clear sequence
- Data_Out  out  CHANNELS*(N+1)  registered read data, same packing as Data_In
- Rd_Valid  out  1  one-cycle pulse, Data_Out freshly updated
- Bank  out  1  index of the active (read) bank
- Busy  out  1  clear sequence in progress
- Parity_Err  out  CHANNELS  per-channel parity mismatch, qualified by Rd_Valid

## Operation
- Storage: 2 banks x CHANNELS x 2^ADDR_W words. Reads use bank Bank. Writes use bank ~Bank (the shadow).
- Write: when Wr_En[c]=1 in IDLE, Data_In channel c is stored at Wr_Addr in the shadow bank of channel c. Channels are independent.
- Read: when Rd_En=1 in IDLE, all channels' active-bank words at Rd_Addr are registered into Data_Out. Data_Out holds its value otherwise.
- Swap: when Swap=1 in IDLE, Bank toggles. Contents are untouched.
- Simultaneous events in one cycle all use the pre-edge Bank. A write goes to the old shadow bank, a read comes from the old active bank, then Bank toggles. So data written in a cycle together with Swap is readable immediately after the swap.
- FSM states:
  - IDLE -> CLEAR on Clear=1. The clear counter loads 0.
  - In CLEAR, each edge zeroes address counter in both banks of all channels, then increments the counter.
  - CLEAR -> IDLE on the edge that zeroes address 2^ADDR_W-1.
- While Busy: Wr_En, Rd_En and Swap are ignored, Rd_Valid stays 0, and a new Clear is ignored.
- Address counter and addresses wrap naturally. No out-of-range condition exists.
- Reset:
  - Bank=0, Data_Out=0, Rd_Valid=0, Busy=0, Parity_Err=0, state IDLE, counter 0.
  - Storage is not reset; its contents are undefined until written or cleared.
  - Reset during CLEAR aborts the sequence; already-cleared words stay zero and the rest keep their contents.

## Timing
- Write latency: data is readable through the shadow bank after a Swap. Earliest read of a written word: write at edge k, Swap at edge k (or later), Rd_En at edge k+1, Data_Out valid after edge k+1.
- Read latency: 1 cycle. Rd_En sampled at edge k, then Data_Out and Rd_Valid=1 during cycle k..k+1. Rd_Valid drops after edge k+1 unless Rd_En is held. Back-to-back reads run one per cycle.
- Clear: Clear sampled at edge k, Busy=1 from edge k through edge k+2^ADDR_W. That is exactly 2^ADDR_W cycles with Busy high; the first accepted command is at edge k+2^ADDR_W+1.
- Bank changes on the edge that samples Swap. There are no combinational paths from inputs to outputs.

## Configuration
- MEMBLOCK_PARITY_EN defined:
  - Each stored word carries one extra even-parity bit, computed on write; clear writes a data+parity pair of 0.
  - On a read, Parity_Err[c] is registered alongside Data_Out and is 1 when the recomputed parity differs from the stored bit. It resets to 0.
- MEMBLOCK_PARITY_EN undefined:
  - No parity storage is built.
  - Parity_Err is tied to 0.
  - Port list is unchanged.

## Test plan
- Reset then Clear (ADDR_W=4) -> Busy high exactly 16 cycles; afterwards read each address of both banks (with a Swap between) -> Data_Out all 0, Rd_Valid one pulse per read.
- Write ch0=9'h1A5 at addr 3 (Bank=0), Rd_En addr 3 with no Swap -> 0 (active bank). Then Swap and read -> Bank=1, ch0=9'h1A5.
- Same-cycle Wr_En=3'b111 at addr 7 with data 9'h001/9'h002/9'h003 plus Swap, Rd_En addr 7 next cycle -> 9'h001/9'h002/9'h003.
- Wr_En, Rd_En and Swap asserted during Busy -> no writes, Rd_Valid=0, Bank unchanged. Assert Reset at cycle 5 of a clear -> Busy=0 and Bank=0 immediately, addresses 0-3 read 0, address 10 keeps its prior value.
- With MEMBLOCK_PARITY_EN: write 9'h0FF, force-flip a stored data bit, read -> Parity_Err[0]=1 together with Rd_Valid. Unforced words -> Parity_Err=0.
